// File: rtl/bundle_element_feeder.sv
// Sequencer for the bundling stage: for each element index it streams that element of every
// source hypervector to the accumulator, then writes the accumulator's cut result back.
module bundle_element_feeder #(
  parameter int unsigned HV_DATA_WIDTH = 32,
  parameter int unsigned HV_DIM        = 1024,
  parameter int unsigned MAX_HV        = 16,
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned MEM_LATENCY   = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned NumW  = $clog2(MAX_HV + 1),
  localparam int unsigned ElemW = $clog2(HV_DIM)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NumW-1:0]          num_hv,
  output logic                     busy,
  output logic                     finished,
  output logic                     cfg_err,
  output logic                     mem_rd,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [HV_DATA_WIDTH-1:0] mem_rdata,
  output logic                     acc_valid,
  output logic                     acc_first,
  output logic                     acc_last,
  output logic [HV_DATA_WIDTH-1:0] acc_data,
  input  logic                     acc_ready,
  input  logic                     acc_done,
  input  logic [HV_DATA_WIDTH-1:0] acc_result,
  output logic                     res_wr,
  output logic [ElemW-1:0]         res_addr,
  output logic [HV_DATA_WIDTH-1:0] res_data
);

  localparam int unsigned CntMax = (MEM_LATENCY > SETTLE_CYCLES) ? MEM_LATENCY : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StRead, StWait, StPresent, StHoldoff, StDrain, StSettle, StWrite
  } state_e;

  state_e                   state_q;
  logic [NumW-1:0]          num_q;
  logic [NumW-1:0]          h_q;
  logic [ElemW-1:0]         e_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [CntW-1:0]          cnt_q;
  logic                     busy_q, finished_q, cfg_err_q, mem_rd_q, res_wr_q;
  logic [HV_DATA_WIDTH-1:0] acc_data_q, res_data_q;

  logic is_last_hv, is_last_elem;
  assign is_last_hv   = (h_q == num_q - NumW'(1));
  assign is_last_elem = (e_q == ElemW'(HV_DIM - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      num_q      <= '0;
      h_q        <= '0;
      e_q        <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      acc_data_q <= '0;
      res_data_q <= '0;
    end else begin
      mem_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      finished_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_hv < NumW'(2) || num_hv > NumW'(MAX_HV)) begin
              cfg_err_q <= 1'b1;
            end else begin
              num_q    <= num_hv;
              h_q      <= '0;
              e_q      <= '0;
              addr_q   <= '0;
              busy_q   <= 1'b1;
              mem_rd_q <= 1'b1;
              state_q  <= StRead;
            end
          end
        end
        StRead: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == CntW'(MEM_LATENCY - 1)) begin
            acc_data_q <= mem_rdata;
            state_q    <= StPresent;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPresent: begin
          if (acc_ready) begin
            if (is_last_hv) begin
              cnt_q   <= '0;
              state_q <= StDrain;
            end else begin
              h_q     <= h_q + NumW'(1);
              // Next hypervector's copy of the same element sits HV_DIM words further on.
              addr_q  <= addr_q + ADDR_WIDTH'(HV_DIM);
              state_q <= StHoldoff;
            end
          end
        end
        StHoldoff: begin
          mem_rd_q <= 1'b1;
          state_q  <= StRead;
        end
        StDrain: begin
          // First drain cycle skips acc_done: it may still be high from the previous element.
          if (cnt_q == '0) begin
            cnt_q <= CntW'(1);
          end else if (acc_done) begin
            cnt_q   <= '0;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            res_wr_q   <= 1'b1;
            res_data_q <= acc_result;
            finished_q <= is_last_elem;
            state_q    <= StWrite;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWrite: begin
          if (is_last_elem) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            e_q      <= e_q + ElemW'(1);
            h_q      <= '0;
            addr_q   <= ADDR_WIDTH'(e_q) + ADDR_WIDTH'(1);
            mem_rd_q <= 1'b1;
            state_q  <= StRead;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The beat fires in the same cycle the accumulator shows ready.
  assign acc_valid = (state_q == StPresent) && acc_ready;
  assign acc_first = acc_valid && (h_q == '0);
  assign acc_last  = acc_valid && is_last_hv;

  assign busy     = busy_q;
  assign finished = finished_q;
  assign cfg_err  = cfg_err_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = addr_q;
  assign acc_data = acc_data_q;
  assign res_wr   = res_wr_q;
  assign res_addr = e_q;
  assign res_data = res_data_q;

endmodule

// File: tb/tb_bundle_element_feeder.sv
// Bench for bundle_element_feeder: random memory contents and accumulator behaviour, checked each
// cycle against a timeline model of reads, beats and result writes.
module tb_bundle_element_feeder;
  localparam int unsigned DW = 32, D = 4, MAXHV = 16, AW = 6, LAT = 3, SET = 2;
  localparam int unsigned NW = $clog2(MAXHV + 1), EW = $clog2(D);
  localparam logic [31:0] POS_ONE = 32'h3F80_0000, NEG_ONE = 32'hBF80_0000;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [NW-1:0] num_hv = '0;
  logic          busy, finished, cfg_err, mem_rd, acc_valid, acc_first, acc_last, res_wr;
  logic [AW-1:0] mem_addr;
  logic [EW-1:0] res_addr;
  logic [DW-1:0] mem_rdata, acc_data, res_data;
  logic [DW-1:0] acc_result = '0;
  logic          acc_ready = 1'b0, acc_done = 1'b0;

  bundle_element_feeder #(
    .HV_DATA_WIDTH(DW), .HV_DIM(D), .MAX_HV(MAXHV), .ADDR_WIDTH(AW),
    .MEM_LATENCY(LAT), .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_hv(num_hv), .busy(busy),
    .finished(finished), .cfg_err(cfg_err), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .acc_valid(acc_valid), .acc_first(acc_first), .acc_last(acc_last),
    .acc_data(acc_data), .acc_ready(acc_ready), .acc_done(acc_done), .acc_result(acc_result),
    .res_wr(res_wr), .res_addr(res_addr), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // HV memory with LAT-cycle read pipeline; garbage when not reading.
  logic [DW-1:0] mem [MAXHV*D];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_rd ? mem[mem_addr] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Bipolar cut of element e: +1.0 if most of the n source words are non-negative, else -1.0.
  function automatic logic [31:0] exp_cut(input int n, input int e);
    int pos = 0;
    for (int h = 0; h < n; h++) if (!mem[h*D+e][31]) pos++;
    return (2 * pos > n) ? POS_ONE : NEG_ONE;
  endfunction

  // Reference model: times of the next read, earliest beat, result write, cfg_err pulse.
  bit m_act = 0, act0, beat_pend = 0, e_rd, e_val, e_wr;
  int m_n, m_e, m_h, t_rd = -1, t_beat = -1, t_wr = -1, drain_from = -1, cfg_at = -1;
  bit o_beat = 0, o_last = 0, o_wr = 0;
  logic [31:0] o_data = '0;
  int rd_log[$], wa_log[$];
  logic [31:0] wr_log[$];
  int n_fin = 0, n_cfg = 0, n_rd = 0, n_beat = 0;
  bit fin_seen = 0, rd2_seen = 0;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk("reset_outputs", {busy, finished, cfg_err, mem_rd, mem_addr, acc_valid, acc_first,
          acc_last, acc_data, res_wr, res_addr, res_data}, '0);
      m_act = 0; beat_pend = 0; t_rd = -1; t_wr = -1; drain_from = -1; cfg_at = -1;
      o_beat = 0; o_last = 0; o_wr = 0;
    end else begin
      act0  = m_act;
      e_rd  = m_act && cyc == t_rd;
      e_val = m_act && beat_pend && cyc >= t_beat && acc_ready;
      e_wr  = m_act && cyc == t_wr;
      chk("busy", busy, m_act);
      chk("mem_rd", mem_rd, e_rd);
      chk("acc_valid", acc_valid, e_val);
      chk("acc_first", acc_first, e_val && m_h == 0);
      chk("acc_last", acc_last, e_val && m_h == m_n - 1);
      chk("res_wr", res_wr, e_wr);
      chk("finished", finished, e_wr && m_e == D - 1);
      chk("cfg_err", cfg_err, cyc == cfg_at);
      if (e_rd) chk("mem_addr", mem_addr, m_h * D + m_e);
      if (e_val) chk("acc_data", acc_data, mem[m_h*D+m_e]);
      if (e_wr) begin
        chk("res_addr", res_addr, m_e);
        chk("res_data", res_data, exp_cut(m_n, m_e));
      end
      if (mem_rd) begin rd_log.push_back(int'(mem_addr)); n_rd++; end
      if (mem_rd && mem_addr == AW'(2)) rd2_seen = 1;
      if (res_wr) begin wr_log.push_back(res_data); wa_log.push_back(int'(res_addr)); end
      if (finished) begin n_fin++; fin_seen = 1; end
      if (cfg_err) n_cfg++;
      if (acc_valid) n_beat++;
      o_beat = acc_valid; o_last = acc_last; o_data = acc_data; o_wr = res_wr;
      if (e_rd) begin beat_pend = 1; t_beat = cyc + LAT + 1; end
      if (e_val) begin
        beat_pend = 0;
        if (m_h < m_n - 1) begin m_h++; t_rd = cyc + 2; end
        else drain_from = cyc + 2;
      end
      if (drain_from >= 0 && cyc >= drain_from && acc_done) begin
        drain_from = -1; t_wr = cyc + SET + 1;
      end
      if (e_wr) begin
        t_wr = -1;
        if (m_e < D - 1) begin m_e++; m_h = 0; t_rd = cyc + 1; end
        else m_act = 0;
      end
      if (start && !act0) begin
        if (int'(num_hv) >= 2 && int'(num_hv) <= MAXHV) begin
          m_act = 1; m_n = int'(num_hv); m_e = 0; m_h = 0; t_rd = cyc + 1;
        end else cfg_at = cyc + 1;
      end
    end
  end

  // Accumulator stand-in. bp_mode: 0 random ready, 1 low 7 cycles after each beat, 2 always.
  int bp_mode = 2, dly_fix = -1;
  int block = 0, pos = 0, cnt = 0, lb = -100, rise = 0, dly = 0;
  bit pend = 0, spur = 0;
  logic [31:0] cut_v = '0;
  initial forever begin
    @(posedge clk); #1;
    if (!reset_n) begin
      block = 0; pos = 0; cnt = 0; pend = 0; spur = 0;
      acc_ready = 0; acc_done = 0; acc_result = $urandom;
    end else begin
      if (o_beat) begin
        cnt++;
        if (!o_data[31]) pos++;
        block = (bp_mode == 1) ? 7 : (bp_mode == 2) ? 0 : int'($urandom_range(0, 2));
        if (o_last) begin
          dly   = (dly_fix < 0) ? int'($urandom_range(0, 4)) : dly_fix;
          lb    = cyc - 1;
          rise  = cyc + dly;
          pend  = 1;
          spur  = (dly >= 2) && ($urandom_range(0, 1) == 1);
          cut_v = (2 * pos > cnt) ? POS_ONE : NEG_ONE;
          pos = 0; cnt = 0;
        end
      end
      if (o_wr) pend = 0;
      if (block > 0) begin acc_ready = 0; block--; end
      else acc_ready = (bp_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      acc_done   = (pend && cyc >= rise) || (spur && cyc == lb + 1);
      acc_result = (pend && cyc >= rise + SET) ? cut_v : $urandom;
    end
  end

  task automatic tick(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input int n);
    fin_seen = 0;
    start = 1; num_hv = NW'(n);
    tick(1);
    start = 0;
  endtask

  task automatic wait_finish(input int budget);
    int k = 0;
    while (!fin_seen && k < budget) begin tick(1); k++; end
    tests++;
    if (!fin_seen) begin
      fails++;
      $display("FAIL finish_timeout: no finished pulse within %0d cycles", budget);
    end
    fin_seen = 0;
  endtask

  logic [31:0] quarter [3] = '{32'h3E80_0000, 32'h3F00_0000, 32'h3F40_0000};
  int exp_rd [6] = '{0, 4, 8, 1, 5, 9};
  int fin0, cfg0, rd0, beat0, k;

  initial begin
    for (int i = 0; i < MAXHV * D; i++) mem[i] = '0;
    reset_n = 0; tick(3);
    reset_n = 1; tick(2);

    // Basic bundle: word h*4+e = 0.25*(h+1).
    for (int h = 0; h < MAXHV; h++)
      for (int e = 0; e < D; e++) mem[h*D+e] = (h < 3) ? quarter[h] : '0;
    bp_mode = 2; dly_fix = -1;
    rd_log.delete(); wr_log.delete(); fin0 = n_fin;
    chk("model_cut_basic", exp_cut(3, 0), POS_ONE);
    do_start(3); wait_finish(2000); tick(2);
    chk("basic_read_count", rd_log.size(), 12);
    for (int i = 0; i < 6; i++) chk("basic_read_order", rd_log[i], exp_rd[i]);
    chk("basic_read_last", rd_log[rd_log.size()-1], 11);
    chk("basic_write_count", wr_log.size(), 4);
    foreach (wr_log[i]) chk("basic_res_data", wr_log[i], POS_ONE);
    chk("basic_finished_once", n_fin - fin0, 1);
    chk("basic_busy_after", busy, 0);

    // Rejected configurations.
    cfg0 = n_cfg; rd0 = n_rd;
    do_start(1); tick(2);
    do_start(0); tick(2);
    do_start(MAXHV + 1); tick(2);
    chk("cfg_err_pulses", n_cfg - cfg0, 3);
    chk("cfg_err_no_reads", n_rd - rd0, 0);
    chk("cfg_err_busy", busy, 0);

    // Random runs, with a start pulse while busy that must be ignored.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < MAXHV * D; i++) mem[i] = $urandom;
      bp_mode = 0; dly_fix = -1;
      do_start(int'($urandom_range(2, MAXHV)));
      tick(6);
      start = 1; num_hv = NW'($urandom_range(0, MAXHV + 1)); tick(1); start = 0;
      wait_finish(6000); tick(3);
    end

    // Backpressure: ready low 7 cycles after each beat.
    for (int i = 0; i < MAXHV * D; i++) mem[i] = $urandom;
    bp_mode = 1; beat0 = n_beat;
    do_start(4); wait_finish(6000); tick(2);
    chk("bp_beat_count", n_beat - beat0, 4 * D);

    // Done arrives 10 cycles after the last beat.
    bp_mode = 2; dly_fix = 10; wr_log.delete();
    do_start(2); wait_finish(3000); tick(2);
    chk("done_delay_writes", wr_log.size(), D);
    dly_fix = -1;

    // Reset while waiting on the element-2 read, then a clean run.
    do_start(5); rd2_seen = 0; k = 0;
    while (!rd2_seen && k < 2000) begin tick(1); k++; end
    chk("reset_run_reached_elem2", rd2_seen, 1);
    #1 reset_n = 0;
    #1 chk("reset_async_outputs", {busy, finished, cfg_err, mem_rd, mem_addr, acc_valid,
           acc_first, acc_last, acc_data, res_wr, res_addr, res_data}, '0);
    tick(2); reset_n = 1; tick(2);
    wr_log.delete(); wa_log.delete(); fin0 = n_fin;
    do_start(2); wait_finish(3000); tick(2);
    chk("post_reset_write_count", wa_log.size(), D);
    foreach (wa_log[i]) chk("post_reset_res_addr", wa_log[i], i);
    chk("post_reset_finished_once", n_fin - fin0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bundle_element_feeder.md
Name: bundle_element_feeder

Overview:
- Upstream sequencer for the bipolar element-addition-cut bundling stage.
- For each element index of a hypervector, reads that element from every source hypervector in HV memory.
- Streams those elements to the accumulator over its valid/first/last/ready/done handshake.
- Captures the cut result after each element and writes it to the result memory, then moves to the next element, covering all HV_DIM elements.

Parameters:
- HV_DATA_WIDTH, 32, width of one FP32 element.
- HV_DIM, 1024, elements per hypervector.
- MAX_HV, 16, maximum number of hypervectors bundled.
- ADDR_WIDTH, 14, HV memory address width; must satisfy ADDR_WIDTH >= clog2(MAX_HV*HV_DIM).
- MEM_LATENCY, 2, HV memory read latency in cycles (>=1).
- SETTLE_CYCLES, 2, cycles between accumulator done rising and acc_result being valid; covers compare latency.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start request; honoured only in S_IDLE.
- num_hv  in  clog2(MAX_HV+1)  number of hypervectors to bundle; sampled on start.
- busy  out  1  high from the cycle after an accepted start until finished.
- finished  out  1  one-cycle pulse when the last element result is written.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- mem_rd  out  1  HV memory read strobe.
- mem_addr  out  ADDR_WIDTH  read address = h*HV_DIM + e.
- mem_rdata  in  HV_DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_rd.
- acc_valid  out  1  beat strobe to the accumulator.
- acc_first  out  1  beat is hypervector 0.
- acc_last  out  1  beat is hypervector num_hv-1.
- acc_data  out  HV_DATA_WIDTH  beat data.
- acc_ready  in  1  accumulator ready.
- acc_done  in  1  accumulator done.
- acc_result  in  HV_DATA_WIDTH  accumulator cut output.
- res_wr  out  1  result write strobe.
- res_addr  out  clog2(HV_DIM)  result address = e.
- res_data  out  HV_DATA_WIDTH  result data.

Behaviour:
- Reset: all outputs 0. State S_IDLE. Counters e and h = 0. Latched num_hv = 0.
- S_IDLE, start=1:
  - num_hv < 2 or num_hv > MAX_HV: no state change; cfg_err=1 for one cycle.
  - Otherwise: latch num_hv, e=0, h=0, busy<=1, go to S_READ.
  - start while busy is ignored.
- S_READ: mem_rd=1 for one cycle, mem_addr = h*HV_DIM + e. Compute the address incrementally; no multiplier. Go to S_WAIT.
- S_WAIT: count MEM_LATENCY cycles. On the final count, register mem_rdata into acc_data and go to S_PRESENT.
- S_PRESENT: wait for acc_ready=1. In that cycle drive acc_valid=1, acc_first=(h==0), acc_last=(h==num_hv-1) for exactly one cycle.
  - h<num_hv-1: h<=h+1, go to S_HOLDOFF.
  - Otherwise: go to S_DRAIN.
- S_HOLDOFF: one cycle, acc_ready ignored, because the accumulator updates ready one cycle late. Then go to S_READ.
- S_DRAIN:
  - Ignore acc_done in the first cycle of this state, since done may still be stale high.
  - Afterwards wait for acc_done=1, then go to S_SETTLE.
- S_SETTLE: count SETTLE_CYCLES cycles, then go to S_WRITE.
- S_WRITE: res_wr=1 for one cycle, res_addr=e, res_data=acc_result.
  - e<HV_DIM-1: e<=e+1, h<=0, go to S_READ.
  - e==HV_DIM-1: finished=1 for one cycle, busy<=0, go to S_IDLE.
- acc_valid is never high in two consecutive cycles.
- acc_data is stable from S_PRESENT entry until the next S_WAIT completes.
- Wrap-around: e and h never exceed HV_DIM-1 and num_hv-1. The address increment uses ADDR_WIDTH-bit arithmetic with no overflow, given the parameter constraint.
- acc_ready stuck low: remain in S_PRESENT indefinitely; no timeout.
- acc_done stuck low: remain in S_DRAIN.
- Reset mid-operation: immediate return to reset values; no res_wr or finished is issued.
- One start produces exactly HV_DIM result writes, in ascending address order.

Test Plan:
- Basic bundle: num_hv=3, HV_DIM=4, mem h*4+e holds 0.25*(h+1) (FP32). Expect:
  - 12 reads, in order 0,4,8,1,5,9,...
  - first asserted on h=0 beats, last on h=2 beats.
  - With the real accumulator, res_data per element = 1.5 (0x3FC00000) clipped to 0x3F800000.
  - finished pulses once; busy low afterwards.
- Config error: start with num_hv=1, then num_hv=0, then num_hv=MAX_HV+1. Each gives a cfg_err pulse; busy stays 0; no mem_rd.
- Backpressure: model acc_ready low for 7 cycles after each beat. acc_valid stays 0 until ready returns. Data and order are unchanged. No double beats.
- Latency sweep: MEM_LATENCY=1 and 4 with known memory pattern. acc_data equals the memory word for every beat.
- Done handshake: delay acc_done 10 cycles after the last beat. Expect no res_wr before acc_done + SETTLE_CYCLES. res_wr occurs exactly once per element.
- Reset mid-run: assert reset_n=0 during S_WAIT of element 2. All outputs are 0 immediately. A new start with num_hv=2 completes normally from element 0.
